interval_timer: RTL and testbench

Programmable down-counting interval timer built on the team's gate-level primitive library. It uses toggle flip-flops for the count bits and and/xor gate cells for toggle-enable and compare logic. It sits directly downstream of the 2-input gate cells and toggle flip-flop, consuming them as its datapath. It serves as the timing source for higher-level control blocks, in one-shot or periodic mode.

---
 rtl/interval_timer_pkg.sv | 11 +
 rtl/interval_timer_tff_down_counter.sv | 36 +++
 rtl/interval_timer.sv | 108 ++++++++++
 tb/tb_interval_timer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/interval_timer_pkg.sv
// rtl/interval_timer_pkg.sv - shared state encoding and defaults for interval_timer
package interval_timer_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/interval_timer_tff_down_counter.sv
// rtl/interval_timer_tff_down_counter.sv - toggle-flip-flop down counter with and-chain borrow
module tff_down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dec,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] t;

  // Bit i toggles when decrementing and every lower bit is 0 (borrow ripples up).
  always_comb begin
    t = '0;
    for (int i = 0; i < WIDTH; i++) begin
      t[i] = dec;
      for (int j = 0; j < i; j++) begin
        t[i] = t[i] & ~q[j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (ld) begin
      q <= ld_val;
    end else begin
      q <= q ^ t;
    end
  end

endmodule

// File: rtl/interval_timer.sv
// rtl/interval_timer.sv - programmable one-shot/periodic down-counting interval timer
module interval_timer
  import interval_timer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic             tick,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             expire,
  output logic             err
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] eff_reload;
  logic             eff_zero;
  logic             is_one;
  logic             cnt_ld, cnt_dec;
  logic             expire_d, err_d;

  // A load on the same edge as a start or auto-reload takes effect immediately.
  assign eff_reload = load ? load_val : reload_q;
  assign eff_zero   = ~|eff_reload;
  assign is_one     = &(~(count ^ ONE));

  tff_down_counter #(.WIDTH(WIDTH)) u_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .dec    (cnt_dec),
    .ld     (cnt_ld),
    .ld_val (eff_reload),
    .q      (count)
  );

  always_comb begin
    state_d  = state_q;
    cnt_ld   = 1'b0;
    cnt_dec  = 1'b0;
    expire_d = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!stop && start) begin
          if (eff_zero) begin
            err_d = 1'b1;
          end else begin
            cnt_ld  = 1'b1;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (start) begin
          cnt_ld = 1'b1;
          if (eff_zero) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (tick) begin
          if (is_one) begin
            expire_d = 1'b1;
            // A zero reload cannot be held in RUN, so it ends like a one-shot.
            if (periodic && !eff_zero) begin
              cnt_ld = 1'b1;
            end else begin
              cnt_dec = 1'b1;
              state_d = IDLE;
            end
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      reload_q <= '0;
      expire   <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q <= state_d;
      expire  <= expire_d;
      err     <= err_d;
      if (load) begin
        reload_q <= load_val;
      end
    end
  end

  assign busy = (state_q == RUN);

endmodule

// File: tb/tb_interval_timer.sv
// tb/tb_interval_timer.sv - table-driven self-checking bench for interval_timer
module tb_interval_timer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       periodic = 1'b0;
  logic       tick = 1'b0;
  logic [7:0] count;
  logic       busy, expire, err;

  int n_checks = 0;
  int n_fail = 0;

  interval_timer #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .stop     (stop),
    .periodic (periodic),
    .tick     (tick),
    .count    (count),
    .busy     (busy),
    .expire   (expire),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic [7:0] lv;
    logic       st;
    logic       sp;
    logic       per;
    logic       tk;
    logic [7:0] ec;
    logic       eb;
    logic       ee;
    logic       er;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic ld, logic [7:0] lv, logic st, logic sp, logic per,
                              logic tk, logic [7:0] ec, logic eb, logic ee, logic er);
    vec_t v;
    v.ld = ld; v.lv = lv; v.st = st; v.sp = sp; v.per = per; v.tk = tk;
    v.ec = ec; v.eb = eb; v.ee = ee; v.er = er;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic [7:0] lv, input logic st,
                       input logic sp, input logic per, input logic tk);
    load = ld; load_val = lv; start = st; stop = sp; periodic = per; tick = tk;
  endtask

  initial begin
    int n_exp;

    //           ld lv st sp per tk   count busy exp err
    // one-shot, reload 3
    vecs.push_back(mk(1, 3, 0, 0, 0, 1,   0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1,   3, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,   2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,   1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,   0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,   0, 0, 0, 0));
    // periodic, reload 2 loaded on the start edge
    vecs.push_back(mk(1, 2, 1, 0, 1, 1,   2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1,   1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1,   2, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1,   1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1,   2, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1,   1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1,   2, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1,   2, 0, 0, 0));
    // gated tick, reload 4
    vecs.push_back(mk(1, 4, 1, 0, 0, 0,   4, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,   3, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,   3, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,   2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,   2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,   1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,   1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,   0, 0, 1, 0));
    // stop beats start at count 5; then start with reload 0
    vecs.push_back(mk(1, 7, 1, 0, 0, 0,   7, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,   6, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,   5, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 1,   5, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0,   5, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,   5, 0, 0, 0));
    // reload reg 9, then load 5 with start; periodic reload uses 5
    vecs.push_back(mk(1, 9, 0, 0, 0, 0,   5, 0, 0, 0));
    vecs.push_back(mk(1, 5, 1, 0, 1, 0,   5, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1,   4, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1,   3, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1,   2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1,   1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1,   5, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1,   4, 1, 0, 0));
    // restart while running: reload, no decrement, no expire
    vecs.push_back(mk(0, 0, 1, 0, 1, 1,   5, 1, 0, 0));
    // periodic with reload 1: expire every ticking cycle
    vecs.push_back(mk(1, 1, 1, 0, 1, 1,   1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1,   1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1,   1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0,   1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0,   1, 0, 0, 0));
    // restart in RUN with a zero reload drops to IDLE with err
    vecs.push_back(mk(1, 3, 1, 0, 0, 0,   3, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0,   0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0));

    #12;
    chk("reset count", count, 0);
    chk("reset busy", busy, 0);
    chk("reset expire", expire, 0);
    chk("reset err", err, 0);

    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].sp, vecs[i].per, vecs[i].tk);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d count", i), count, vecs[i].ec);
      chk($sformatf("row%0d busy", i), busy, vecs[i].eb);
      chk($sformatf("row%0d expire", i), expire, vecs[i].ee);
      chk($sformatf("row%0d err", i), err, vecs[i].er);
    end

    // periodic reload 2 over 6 full periods
    @(negedge clk);
    drive(1, 2, 1, 0, 1, 1);
    @(posedge clk);
    #1;
    chk("per6 start count", count, 2);
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 1);
    n_exp = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("per6 busy c%0d", c), busy, 1);
      chk($sformatf("per6 count c%0d", c), count, (c % 2 == 0) ? 1 : 2);
      if (expire) n_exp++;
    end
    chk("per6 expire total", n_exp, 6);
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 0);
    @(posedge clk);
    #1;
    chk("per6 stop busy", busy, 0);

    // asynchronous reset mid-run
    @(negedge clk);
    drive(1, 3, 1, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("rst run count", count, 3);
    chk("rst run busy", busy, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst count", count, 0);
    chk("async rst busy", busy, 0);
    chk("async rst expire", expire, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post rst expire c%0d", c), expire, 0);
      chk($sformatf("post rst busy c%0d", c), busy, 0);
      chk($sformatf("post rst count c%0d", c), count, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
